npu_requant: RTL and testbench



---
 rtl/npu_requant.sv | 129 ++++++++++++
 tb/tb_npu_requant.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/npu_requant.sv
// Per-channel requantization: acc * Q31 scale, rounding right shift, saturation; 3-stage pipeline.
// Optional fused ReLU via NPU_REQUANT_RELU_EN (negative results clamped to 0 after saturation).
module npu_requant #(
  localparam int M_LEN  = 32,
  localparam int S_LEN  = 32,
  localparam int SH_LEN = 5
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              clear_i,
  input  logic [M_LEN-1:0]  acc_i,
  input  logic [S_LEN-1:0]  mult_i,
  input  logic [SH_LEN-1:0] shift_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [M_LEN-1:0]  data_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam int P_LEN = M_LEN + S_LEN;
  localparam logic [M_LEN-1:0]  ACC_MIN  = {1'b1, {(M_LEN-1){1'b0}}};
  localparam logic [S_LEN-1:0]  MULT_MIN = {1'b1, {(S_LEN-1){1'b0}}};
  localparam logic [P_LEN-1:0]  RND_H    = {{(P_LEN-31){1'b0}}, 1'b1, 30'd0};
  localparam logic [32:0]       H_MAX    = 33'h0_7FFF_FFFF;
  localparam logic [SH_LEN-1:0] SH_ONE   = {{(SH_LEN-1){1'b0}}, 1'b1};
  localparam logic signed [35:0] R_MAX   = 36'sh0_7FFF_FFFF;
  localparam logic signed [35:0] R_MIN   = 36'shF_8000_0000;

  // Handshake: a beat moves on valid & ready at the rising edge. All stages
  // advance together on en; ready_o is en and never looks at valid_i.
  logic en;

  logic signed [M_LEN-1:0] acc1_q;
  logic signed [S_LEN-1:0] mult1_q;
  logic [SH_LEN-1:0]       sh1_q;
  logic                    v1_q;

  logic signed [P_LEN-1:0] prod2_d, prod2_q;
  logic                    ovf2_d, ovf2_q;
  logic [SH_LEN-1:0]       sh2_q;
  logic                    v2_q;

  logic [M_LEN-1:0]        data_d, data_q;
  logic                    v3_q;

  logic [P_LEN-1:0]        p_mag;
  logic [32:0]             h_mag;
  logic                    h_neg;
  logic [33:0]             rnd;
  logic [33:0]             r_mag;
  logic signed [35:0]      r_val;

  assign en      = ready_i | ~v3_q;
  assign ready_o = en;
  assign valid_o = v3_q;
  assign data_o  = data_q;

  assign prod2_d = $signed({{(P_LEN-M_LEN){acc1_q[M_LEN-1]}}, acc1_q}) *
                   $signed({{(P_LEN-S_LEN){mult1_q[S_LEN-1]}}, mult1_q});
  assign ovf2_d  = (acc1_q == ACC_MIN) && (mult1_q == MULT_MIN);

  // Work on magnitudes so both roundings are half-away-from-zero.
  always_comb begin
    p_mag = prod2_q[P_LEN-1] ? -prod2_q : prod2_q;
    h_mag = 33'((p_mag + RND_H) >> 31);
    h_neg = prod2_q[P_LEN-1] & ~ovf2_q;
    if (ovf2_q) begin
      h_mag = H_MAX;
    end
    rnd   = (sh2_q == '0) ? 34'd0 : (34'd1 << (sh2_q - SH_ONE));
    r_mag = ({1'b0, h_mag} + rnd) >> sh2_q;
    r_val = h_neg ? -$signed({2'b00, r_mag}) : $signed({2'b00, r_mag});
    if (r_val > R_MAX) begin
      data_d = R_MAX[M_LEN-1:0];
    end else if (r_val < R_MIN) begin
      data_d = R_MIN[M_LEN-1:0];
    end else begin
      data_d = r_val[M_LEN-1:0];
    end
`ifdef NPU_REQUANT_RELU_EN
    if (data_d[M_LEN-1]) begin
      data_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc1_q  <= '0;
      mult1_q <= '0;
      sh1_q   <= '0;
      prod2_q <= '0;
      ovf2_q  <= 1'b0;
      sh2_q   <= '0;
      data_q  <= '0;
    end else begin
      if (en) begin
        acc1_q  <= acc_i;
        mult1_q <= mult_i;
        sh1_q   <= shift_i;
        prod2_q <= prod2_d;
        ovf2_q  <= ovf2_d;
        sh2_q   <= sh1_q;
      end
      // A flush leaves the last presented output value in place.
      if (en && !clear_i) begin
        data_q <= data_d;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (clear_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (en) begin
      v1_q <= valid_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

endmodule

// File: tb/tb_npu_requant.sv
// Self-checking bench for npu_requant: directed corners, random backpressure stream,
// flush and mid-stream reset, checked against an arithmetic reference model.
module tb_npu_requant;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        clear_i;
  logic [31:0] acc_i;
  logic [31:0] mult_i;
  logic [4:0]  shift_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;

`ifdef NPU_REQUANT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic [31:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int out_cnt = 0;

  npu_requant dut (
    .clk_i   (clk),
    .rstn_i  (rstn_i),
    .clear_i (clear_i),
    .acc_i   (acc_i),
    .mult_i  (mult_i),
    .shift_i (shift_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  // Reference: value = acc*mult/2^31 rounded half away from zero, then /2^shift likewise.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] m,
                                        input logic [4:0] s);
    longint p, h, mag, r;
    longint lim;
    lim = longint'(1) << 31;
    if (a == 32'h8000_0000 && m == 32'h8000_0000) begin
      h = lim - 1;
    end else begin
      p   = longint'($signed(a)) * longint'($signed(m));
      mag = (p < 0) ? -p : p;
      h   = (mag + lim / 2) / lim;
      if (p < 0) h = -h;
    end
    if (s == 0) begin
      r = h;
    end else begin
      mag = (h < 0) ? -h : h;
      r   = (mag + (longint'(1) << (s - 1))) / (longint'(1) << s);
      if (h < 0) r = -r;
    end
    if (r > lim - 1) r = lim - 1;
    if (r < -lim) r = -lim;
    if (RELU && r < 0) r = 0;
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] m, input logic [4:0] s);
    acc_i   = a;
    mult_i  = m;
    shift_i = s;
    valid_i = 1'b1;
  endtask

  // One cycle: observe at the falling edge, advance past the rising edge.
  task automatic tick(output bit accepted);
    accepted = 1'b0;
    @(negedge clk);
    if (rstn_i) begin
      chk("ready_o_rule", 32'(ready_o), 32'(!valid_o || ready_i));
      if (valid_o && ready_i) begin
        out_cnt++;
        if (exp_q.size() == 0) chk("spurious_out", 32'(valid_o), 32'd0);
        else chk("sb_data", data_o, exp_q.pop_front());
      end
      if (clear_i) begin
        exp_q.delete();
      end else if (valid_i && ready_o) begin
        exp_q.push_back(model(acc_i, mult_i, shift_i));
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Beat presented in the cycle after edge N must show valid_o after edge N+3.
  task automatic run_dir(input string tag, input logic [31:0] a, input logic [31:0] m,
                         input logic [4:0] s, input logic [31:0] expv);
    bit ok;
    ready_i = 1'b1;
    drive(a, m, s);
    tick(ok);
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    valid_i = 1'b0;
    tick(ok);
    chk({tag, "_lat_early"}, 32'(valid_o), 32'd0);
    tick(ok);
    chk({tag, "_lat_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_data"}, data_o, expv);
    tick(ok);
  endtask

  initial begin
    bit ok;
    int sent, cyc, out0;
    logic [31:0] b1_exp;
    rstn_i  = 1'b0;
    clear_i = 1'b0;
    ready_i = 1'b1;
    drive(32'd1000, 32'h4000_0000, 5'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_data_o", data_o, 32'd0);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    rstn_i  = 1'b1;
    #1;
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;

    run_dir("scale_pos",  32'd1000,      32'h4000_0000, 5'd0,  32'd500);
    run_dir("scale_half", 32'hFFFF_FFFD, 32'h4000_0000, 5'd0,  RELU ? 32'd0 : 32'hFFFF_FFFE);
    run_dir("sh1_pos",    32'd5,         32'h7FFF_FFFF, 5'd1,  32'd3);
    run_dir("sh1_neg",    32'hFFFF_FFFB, 32'h7FFF_FFFF, 5'd1,  RELU ? 32'd0 : 32'hFFFF_FFFD);
    run_dir("sh2_six",    32'd6,         32'h7FFF_FFFF, 5'd2,  32'd2);
    run_dir("sh2_four",   32'd4,         32'h7FFF_FFFF, 5'd2,  32'd1);
    run_dir("ovf_sh0",    32'h8000_0000, 32'h8000_0000, 5'd0,  32'h7FFF_FFFF);
    run_dir("ovf_sh31",   32'h8000_0000, 32'h8000_0000, 5'd31, 32'd1);
    run_dir("neg_big",    32'hFFFF_FC18, 32'h4000_0000, 5'd0,  RELU ? 32'd0 : 32'hFFFF_FE0C);

    // Random stream under random backpressure.
    out0 = out_cnt;
    sent = 0;
    cyc  = 0;
    valid_i = 1'b0;
    while (sent < 8 && cyc < 400) begin
      if (!valid_i) drive($urandom, $urandom, 5'($urandom_range(0, 31)));
      ready_i = 1'($urandom_range(0, 1));
      tick(ok);
      if (ok) begin
        sent++;
        valid_i = 1'b0;
      end
      cyc++;
    end
    valid_i = 1'b0;
    chk("bp_sent", sent, 32'd8);
    cyc = 0;
    while ((exp_q.size() > 0 || valid_o) && cyc < 400) begin
      ready_i = 1'($urandom_range(0, 1));
      tick(ok);
      cyc++;
    end
    chk("bp_drain", exp_q.size(), 32'd0);
    chk("bp_out_cnt", out_cnt - out0, 32'd8);

    // Flush: three beats pile up behind a stalled output, clear together with ready_i=0.
    ready_i = 1'b0;
    b1_exp = model(32'd123456, 32'h2000_0000, 5'd3);
    drive(32'd123456, 32'h2000_0000, 5'd3);
    tick(ok);
    drive(32'd777, 32'h7FFF_FFFF, 5'd0);
    tick(ok);
    drive(32'hFFFF_0000, 32'h4000_0000, 5'd4);
    tick(ok);
    valid_i = 1'b0;
    chk("stall_valid", 32'(valid_o), 32'd1);
    chk("stall_ready_o", 32'(ready_o), 32'd0);
    tick(ok);
    chk("stall_hold_valid", 32'(valid_o), 32'd1);
    chk("stall_hold_data", data_o, b1_exp);
    clear_i = 1'b1;
    drive(32'd42, 32'h4000_0000, 5'd0);
    tick(ok);
    clear_i = 1'b0;
    valid_i = 1'b0;
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_data_hold", data_o, b1_exp);
    ready_i = 1'b1;
    repeat (5) begin
      tick(ok);
      chk("flush_no_out", 32'(valid_o), 32'd0);
    end

    // Asynchronous reset while the pipeline is full.
    repeat (3) begin
      drive($urandom, $urandom, 5'($urandom_range(0, 8)));
      tick(ok);
    end
    valid_i = 1'b0;
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid_o), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn_i = 1'b1;
    repeat (4) begin
      tick(ok);
      chk("post_rst_no_out", 32'(valid_o), 32'd0);
    end
    chk("end_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
